keypad_scan_ctrl: RTL and testbench
===================================

// Module: keypad_scan_ctrl
// PURPOSE
//  Scans a 4x4 matrix keypad: drives one column low at a time, samples the 4 row
//  inputs, debounces press and release, and encodes the key as a 4-bit code.
//  Avalon-MM slave on the Nios system bus; replaces the raw 4-bit input PIO.
//  Software reads the code and status instead of polling rows directly.
// PARAMETERS
//  SETTLE_CYCLES    16      clocks after a column change before rows are sampled
//  DEBOUNCE_CYCLES  500000  clocks a row pattern must stay stable (10 ms at 50 MHz)
//  CNT_W            20      width of the shared settle/debounce counter (>= clog2 of both)
// PORTS
//  clk        in   1   system clock
//  reset_n    in   1   asynchronous, active-low reset
//  col_n      out  4   column drive, active low, exactly one bit low at any time
//  row_n      in   4   row sense, active low, pulled up externally, asynchronous
//  address    in   2   Avalon word address
//  read       in   1   Avalon read strobe
//  write      in   1   Avalon write strobe
//  writedata  in   32  Avalon write data
//  readdata   out  32  Avalon read data, registered
//  irq        out  1   interrupt, level, active high, registered
// BEHAVIOUR
//  Reset: col_n=4'b1110, col_idx=0, state SCAN, counter=0, readdata=0, irq=0,
//   key_code=0, valid=0, overrun=0, irq_en=0.
//  row_n passes through a 2-flop synchronizer. All FSM decisions use the
//   synchronized value rs. Add 2 cycles of input latency.
//  Register map:
//   0 KEY    R: [3:0] key_code, [8] valid. A read pops the entry: valid clears
//            on the cycle after the read strobe.
//   1 STATUS R: [0] valid, [1] overrun, [2] key_down (state is PRESS or RELEASE).
//   2 CTRL   R/W: [0] irq_en. Writing [1]=1 clears overrun. Bit [1] reads as 0.
//   3        reads 0. Writes are ignored.
//  readdata <= mux(address) on every clock. Read latency is 1 cycle, no waitstates.
//  irq <= irq_en & valid, registered.
//  FSM:
//   SCAN     drive col_idx. After SETTLE_CYCLES, sample rs.
//            - If rs != 4'hF: capture rs as pat, clear the counter, go to DEBOUNCE.
//            - Otherwise: col_idx++ (wraps 3->0), change column, restart settle.
//   DEBOUNCE keep the column. Count while rs == pat.
//            - If rs changes: go to SCAN on the same column and restart settle.
//            - If count reaches DEBOUNCE_CYCLES-1: go to PRESS.
//   PRESS    one cycle. row = index of the lowest low bit of pat.
//            key_code = {row[1:0], col_idx[1:0]}.
//            - If valid=0, or a pop happens this cycle: latch the code, valid=1.
//            - Otherwise: keep the old code and set overrun=1.
//            Then go to RELEASE.
//   RELEASE  keep the column. Count while rs == 4'hF. Any low row resets the count.
//            At DEBOUNCE_CYCLES-1: col_idx++ and go to SCAN.
//  Multiple keys pressed: the lowest row index in the column wins. Other keys in
//   the same column are ignored until release.
//  Pop and PRESS latch in the same cycle: the new key is kept, valid stays 1,
//   overrun is not set.
//  Write to CTRL in the same cycle as an overrun set: the set wins.
//  Reset mid-debounce or mid-release: immediate return to the reset state.
//   The key is not reported.
// STRUCTURE
//  Package keypad_pkg:
//   - FSM state encoding (SCAN, DEBOUNCE, PRESS, RELEASE)
//   - register addresses and bit-field positions
//   - column and row count (4)
//  Sub-module keypad_row_sync: 4-bit 2-flop synchronizer (clk, reset_n, d, q),
//   reset value 4'hF.
//  The settle and debounce counts share one CNT_W counter.
// TESTING (bench: SETTLE_CYCLES=2, DEBOUNCE_CYCLES=8)
//  1 Idle, all row_n=4'hF -> col_n cycles 1110,1101,1011,0111,1110.
//    Each column is held 2+ cycles. valid stays 0 and irq stays 0.
//  2 Press row1 while col2 is driven, held for 20 cycles, irq_en=1
//    -> KEY reads 0x106 and irq=1.
//    -> After the KEY read: valid=0 and irq drops 1 cycle later.
//  3 row_n bounces (toggles every 3 cycles for 12 cycles), then stays stable
//    -> exactly one key reported.
//    -> Release bounces do not produce a second key.
//  4 Two keys reported with no read in between -> KEY keeps the first code,
//    STATUS=0x3. Writing CTRL=0x2 -> STATUS=0x1.
//  5 Rows 0 and 3 pressed together on col1 -> key_code=0x1.
//    Pop in the same cycle as a PRESS -> new code kept, overrun=0.
//  6 Assert reset_n=0 during DEBOUNCE -> col_n=1110, valid=0, readdata=0 at once.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, register map and
// the row-priority helper.
package keypad_pkg;

  localparam int unsigned NUM_COLS    = 4;
  localparam int unsigned NUM_ROWS    = 4;
  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESS,
    ST_RELEASE
  } state_e;

  localparam logic [1:0] ADDR_KEY    = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int unsigned KEY_VALID_BIT    = 8;
  localparam int unsigned ST_VALID_BIT     = 0;
  localparam int unsigned ST_OVERRUN_BIT   = 1;
  localparam int unsigned ST_KEYDOWN_BIT   = 2;
  localparam int unsigned CTRL_IRQ_EN_BIT  = 0;
  localparam int unsigned CTRL_CLR_OVR_BIT = 1;

  // Rows are active low; the lowest-numbered low row wins.
  function automatic logic [1:0] lowest_low(input logic [NUM_ROWS-1:0] pat);
    logic [1:0] idx;
    if (!pat[0])      idx = 2'd0;
    else if (!pat[1]) idx = 2'd1;
    else if (!pat[2]) idx = 2'd2;
    else              idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low row sense lines.
module keypad_row_sync (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner with press/release debounce, exposed as an
// Avalon-MM slave (KEY, STATUS, CTRL) with a level interrupt.
module keypad_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES   = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [3:0]  col_n,
  input  logic [3:0]  row_n,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  import keypad_pkg::*;

  // Settle also covers the synchronizer so the sampled rows belong to the new column.
  localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES + SYNC_STAGES - 1);
  localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_n_q, col_n_d;
  logic [3:0]       pat_q, pat_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             irq_en_q, irq_en_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q;
  logic [3:0]       rs;
  logic             pop;
  logic             ctrl_wr;
  logic             unused_wdata;

  keypad_row_sync u_row_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (row_n),
    .q       (rs)
  );

  assign pop          = read  && (address == ADDR_KEY);
  assign ctrl_wr      = write && (address == ADDR_CTRL);
  assign unused_wdata = ^writedata[31:2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_SCAN;
      cnt_q      <= '0;
      col_idx_q  <= '0;
      col_n_q    <= 4'b1110;
      pat_q      <= '1;
      code_q     <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      irq_en_q   <= 1'b0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      col_idx_q  <= col_idx_d;
      col_n_q    <= col_n_d;
      pat_q      <= pat_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      irq_en_q   <= irq_en_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_en_q & valid_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_idx_d = col_idx_q;
    pat_d     = pat_q;
    code_d    = code_q;
    valid_d   = valid_q & ~pop;
    overrun_d = overrun_q;
    irq_en_d  = irq_en_q;

    if (ctrl_wr) begin
      irq_en_d = writedata[CTRL_IRQ_EN_BIT];
      if (writedata[CTRL_CLR_OVR_BIT]) overrun_d = 1'b0;
    end

    // The PRESS branch is evaluated after the CTRL clear, so an overrun set wins.
    unique case (state_q)
      ST_SCAN: begin
        if (cnt_q != SETTLE_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (rs != '1) begin
            pat_d   = rs;
            state_d = ST_DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (rs != pat_q) begin
          cnt_d   = '0;
          state_d = ST_SCAN;
        end else if (cnt_q == DEBOUNCE_LAST) begin
          cnt_d   = '0;
          state_d = ST_PRESS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRESS: begin
        cnt_d   = '0;
        state_d = ST_RELEASE;
        if (!valid_q || pop) begin
          code_d  = {lowest_low(pat_q), col_idx_q};
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (rs != '1) begin
          cnt_d = '0;
        end else if (cnt_q == DEBOUNCE_LAST) begin
          cnt_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = ST_SCAN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_SCAN;
    endcase

    col_n_d = ~(4'b0001 << col_idx_d);
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_KEY: begin
        readdata_d[3:0]           = code_q;
        readdata_d[KEY_VALID_BIT] = valid_q;
      end
      ADDR_STATUS: begin
        readdata_d[ST_VALID_BIT]   = valid_q;
        readdata_d[ST_OVERRUN_BIT] = overrun_q;
        readdata_d[ST_KEYDOWN_BIT] = (state_q == ST_PRESS) || (state_q == ST_RELEASE);
      end
      ADDR_CTRL:   readdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
      default:     readdata_d = '0;
    endcase
  end

  assign col_n    = col_n_q;
  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a physical keypad model drives row_n from col_n,
// and expected key codes come from row/column arithmetic on the pressed keys.
module tb_keypad_scan_ctrl;

  logic        clk;
  logic        reset_n;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int total;
  int bad;

  // pressed[c] holds a row mask (1 = key closed) for column c
  logic [3:0]  pressed [4];

  int          n, c, cy, cx, minhold, run;
  logic [3:0]  m, mx, my, prev, tgt;
  logic [31:0] d, st;
  bit          onehot_ok, irq_seen, saw_latch, saw_ovr;
  logic [3:0]  seq [$];
  logic [3:0]  exp_cols [5];

  keypad_scan_ctrl #(
    .SETTLE_CYCLES   (2),
    .DEBOUNCE_CYCLES (8),
    .CNT_W           (20)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .col_n     (col_n),
    .row_n     (row_n),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row_n = 4'hF;
    for (int i = 0; i < 4; i++)
      if (!col_n[i]) row_n = row_n & ~pressed[i];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cyc);
    repeat (cyc) @(negedge clk);
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] data);
    @(negedge clk);
    address = a;
    read    = 1'b1;
    @(negedge clk);
    read    = 1'b0;
    address = 2'd1;
    data    = readdata;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] data);
    @(negedge clk);
    address   = a;
    write     = 1'b1;
    writedata = data;
    @(negedge clk);
    write     = 1'b0;
    address   = 2'd1;
    writedata = '0;
  endtask

  task automatic tap(input int col, input logic [3:0] mask);
    pressed[col] = mask;
    tick(60);
    pressed[col] = '0;
    tick(40);
  endtask

  task automatic align(input int col);
    logic [3:0] t;
    int k;
    t = ~(4'b0001 << col);
    k = 0;
    while (col_n === t && k < 50) begin @(negedge clk); k++; end
    while (col_n !== t && k < 100) begin @(negedge clk); k++; end
    chk("align_col", {28'b0, col_n}, {28'b0, t});
  endtask

  function automatic logic [3:0] code_of(input int col, input logic [3:0] mask);
    int r;
    r = 0;
    for (int i = 3; i >= 0; i--) if (mask[i]) r = i;
    return 4'(r * 4 + col);
  endfunction

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0; read = 1'b0; write = 1'b0; address = 2'd1; writedata = '0;
    for (int i = 0; i < 4; i++) pressed[i] = '0;
    exp_cols = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};

    // reset state
    tick(3);
    chk("rst_col_n", {28'b0, col_n}, 32'hE);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;

    // idle scan order and hold times
    prev = col_n; run = 1; minhold = 1000; onehot_ok = 1; irq_seen = 0;
    seq.push_back(col_n);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (col_n !== prev) begin
        if (run < minhold) minhold = run;
        seq.push_back(col_n);
        run = 1;
        prev = col_n;
      end else begin
        run++;
      end
      if ($countones(~col_n) != 1) onehot_ok = 0;
      if (irq !== 1'b0) irq_seen = 1;
    end
    chk("idle_seq_len", {31'b0, seq.size() >= 5}, 32'h1);
    for (int i = 0; i < 5; i++)
      if (i < seq.size()) chk("idle_seq", {28'b0, seq[i]}, {28'b0, exp_cols[i]});
    chk("idle_min_hold", {31'b0, minhold >= 2}, 32'h1);
    chk("idle_onehot", {31'b0, onehot_ok}, 32'h1);
    chk("idle_irq", {31'b0, irq_seen}, 32'h0);
    bus_rd(2'd1, d);
    chk("idle_status", d, 32'h0);

    // row1 on col2 with interrupts enabled
    bus_wr(2'd2, 32'h1);
    pressed[2] = 4'b0010;
    n = 0;
    while (irq !== 1'b1 && n < 100) begin tick(1); n++; end
    chk("irq_rise", {31'b0, irq}, 32'h1);
    bus_rd(2'd0, d);
    chk("key_r1c2", d, 32'h106);
    chk("irq_hold", {31'b0, irq}, 32'h1);
    tick(1);
    chk("irq_drop", {31'b0, irq}, 32'h0);
    bus_rd(2'd1, d);
    chk("status_keydown", d, 32'h4);
    pressed[2] = '0;
    tick(40);
    bus_rd(2'd1, d);
    chk("status_released", d, 32'h0);

    // bouncing press and release reports one key
    c = $urandom_range(3, 0);
    m = 4'b0001 << $urandom_range(3, 0);
    for (int i = 0; i < 4; i++) begin pressed[c] = (i % 2 == 0) ? m : 4'h0; tick(3); end
    pressed[c] = m;
    tick(60);
    for (int i = 0; i < 4; i++) begin pressed[c] = (i % 2 == 0) ? 4'h0 : m; tick(3); end
    pressed[c] = '0;
    tick(40);
    bus_rd(2'd1, d);
    chk("bounce_status", d, 32'h1);
    bus_rd(2'd0, d);
    chk("bounce_key", d, 32'h100 | {28'b0, code_of(c, m)});
    bus_rd(2'd1, d);
    chk("bounce_single", d, 32'h0);

    // two keys without a read: first kept, overrun flagged
    cx = $urandom_range(3, 0);
    c  = (cx + 1) % 4;
    mx = 4'b0001 << $urandom_range(3, 0);
    my = 4'b0001 << $urandom_range(3, 0);
    tap(cx, mx);
    tap(c, my);
    bus_rd(2'd1, d);
    chk("ovr_status", d, 32'h3);
    bus_wr(2'd2, 32'h2);
    bus_rd(2'd1, d);
    chk("ovr_cleared", d, 32'h1);
    bus_rd(2'd2, d);
    chk("ctrl_rd0", d, 32'h0);
    bus_wr(2'd2, 32'h3);
    bus_rd(2'd2, d);
    chk("ctrl_rd1", d, 32'h1);
    tick(2);
    chk("ovr_irq", {31'b0, irq}, 32'h1);
    bus_rd(2'd0, d);
    chk("ovr_key_first", d, 32'h100 | {28'b0, code_of(cx, mx)});
    bus_rd(2'd1, d);
    chk("ovr_empty", d, 32'h0);

    // multiple keys in one column: lowest row wins
    tap(1, 4'b1001);
    bus_rd(2'd0, d);
    chk("multi_r0r3c1", d, 32'h101);
    for (int i = 0; i < 5; i++) begin
      c = $urandom_range(3, 0);
      m = 4'($urandom_range(15, 1));
      tap(c, m);
      bus_rd(2'd0, d);
      chk("rand_key", d, 32'h100 | {28'b0, code_of(c, m)});
    end

    // sweep a single KEY pop across the moment a second key is accepted
    saw_latch = 0; saw_ovr = 0;
    for (int k = 4; k <= 20; k++) begin
      cy = $urandom_range(3, 0);
      cx = (cy + 1) % 4;
      mx = 4'b0001 << $urandom_range(3, 0);
      my = 4'b0001 << $urandom_range(3, 0);
      tap(cx, mx);
      align(cy);
      pressed[cy] = my;
      tick(k);
      bus_rd(2'd0, d);
      tick(60);
      pressed[cy] = '0;
      tick(40);
      bus_rd(2'd1, st);
      chk("pop_press_legal", {31'b0, (st === 32'h1) || (st === 32'h2)}, 32'h1);
      if (st === 32'h1) begin
        saw_latch = 1;
        bus_rd(2'd0, d);
        chk("pop_press_key", d, 32'h100 | {28'b0, code_of(cy, my)});
      end else begin
        saw_ovr = 1;
        bus_wr(2'd2, 32'h3);
      end
    end
    chk("sweep_saw_latch", {31'b0, saw_latch}, 32'h1);
    chk("sweep_saw_ovr", {31'b0, saw_ovr}, 32'h1);

    // reset during debounce
    bus_wr(2'd2, 32'h1);
    tap(0, 4'b0100);
    cy = $urandom_range(3, 1);
    align(cy);
    pressed[cy] = 4'b0001;
    tick(6);
    chk("pre_rst_status", readdata, 32'h1);
    chk("pre_rst_irq", {31'b0, irq}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_col_n", {28'b0, col_n}, 32'hE);
    chk("mid_rst_readdata", readdata, 32'h0);
    chk("mid_rst_irq", {31'b0, irq}, 32'h0);
    pressed[cy] = '0;
    @(negedge clk);
    reset_n = 1'b1;
    tick(60);
    bus_rd(2'd1, d);
    chk("post_rst_status", d, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
